// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Board-level reset sequencer. Holds NUM_OUTS reset domains
//               asserted until the PLL is locked and the push-button is
//               released, then releases them LSB first at fixed intervals.
//               Reasserts all domains on lock loss, a debounced button press
//               or a software request, and records the cause of the last
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_OUTS        = 4,
    parameter int HOLD_CYCLES     = 32,
    parameter int STAGE_GAP       = 8,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic                btn_n,
    input  logic                sw_reset,
    output logic [NUM_OUTS-1:0] rst_out,
    output logic                ready,
    output logic [1:0]          cause
);

    localparam logic [2:0] c_ST_ASSERT    = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_HOLD      = 3'd2;
    localparam logic [2:0] c_ST_RELEASE   = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;

    localparam logic [1:0] c_CAUSE_POR  = 2'd0;
    localparam logic [1:0] c_CAUSE_LOCK = 2'd1;
    localparam logic [1:0] c_CAUSE_BTN  = 2'd2;
    localparam logic [1:0] c_CAUSE_SW   = 2'd3;

    localparam int c_STAGE_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
    localparam logic [CNT_WIDTH-1:0] c_DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_STAGE_W-1:0] c_STAGE_FIRST = c_STAGE_W'(1);
    localparam logic [c_STAGE_W-1:0] c_STAGE_LAST  = c_STAGE_W'(NUM_OUTS - 1);
    localparam logic [NUM_OUTS-1:0]  c_ALL_ON      = {NUM_OUTS{1'b1}};

    logic                 r_lock_meta;
    logic                 r_lock_s;
    logic                 r_btn_meta;
    logic                 r_btn_s;
    logic                 r_btn_db;
    logic [CNT_WIDTH-1:0] r_db_cnt;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [c_STAGE_W-1:0] r_stage;
    logic [c_STAGE_W-1:0] w_stage_next;
    logic [NUM_OUTS-1:0]  r_rst;
    logic [NUM_OUTS-1:0]  w_rst_next;
    logic                 r_ready;
    logic                 w_ready_next;
    logic [1:0]           r_cause;
    logic [1:0]           w_cause_next;

    logic                 w_cause_hit;
    logic [1:0]           w_cause_code;
    logic                 w_hold_done;
    logic                 w_gap_done;

    assign rst_out = r_rst;
    assign ready   = r_ready;
    assign cause   = r_cause;

    assign w_hold_done = (r_cnt == c_HOLD_LAST);
    assign w_gap_done  = (r_cnt == c_GAP_LAST);

    // Two-flop synchronisers; lock idles unlocked, button idles released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_meta  <= 1'b1;
            r_btn_s     <= 1'b1;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
            r_btn_meta  <= btn_n;
            r_btn_s     <= r_btn_meta;
        end
    end

    // Debounce: accept a new button level only after it has persisted unbroken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_btn_db <= r_btn_s;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_CNT_ONE;
        end
    end

    // Reset cause decode with lock loss > button > software priority.
    // Lock and button are level-checked: both were high on entry to HOLD, so
    // a low level in HOLD/RELEASE/RUN is necessarily a fresh falling edge.
    always_comb begin
        w_cause_hit  = 1'b1;
        w_cause_code = c_CAUSE_POR;
        if (!r_lock_s) begin
            w_cause_code = c_CAUSE_LOCK;
        end else if (!r_btn_db) begin
            w_cause_code = c_CAUSE_BTN;
        end else if (sw_reset) begin
            w_cause_code = c_CAUSE_SW;
        end else begin
            w_cause_hit = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_ASSERT;
            r_cnt   <= '0;
            r_stage <= '0;
            r_rst   <= c_ALL_ON;
            r_ready <= 1'b0;
            r_cause <= c_CAUSE_POR;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_stage <= w_stage_next;
            r_rst   <= w_rst_next;
            r_ready <= w_ready_next;
            r_cause <= w_cause_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_ASSERT:    w_state_next = c_ST_WAIT_LOCK;
            c_ST_WAIT_LOCK: if (r_lock_s && r_btn_db) w_state_next = c_ST_HOLD;
            c_ST_HOLD: begin
                if (w_cause_hit) begin
                    w_state_next = c_ST_ASSERT;
                end else if (w_hold_done) begin
                    w_state_next = (NUM_OUTS == 1) ? c_ST_RUN : c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                if (w_cause_hit) begin
                    w_state_next = c_ST_ASSERT;
                end else if (w_gap_done && (r_stage == c_STAGE_LAST)) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN:       if (w_cause_hit) w_state_next = c_ST_ASSERT;
            default:        w_state_next = c_ST_ASSERT;
        endcase
    end

    // Output/counter logic; releases shift a zero in from the LSB so domains
    // can only ever drop in order.
    always_comb begin
        w_rst_next   = r_rst;
        w_ready_next = r_ready;
        w_cause_next = r_cause;
        w_cnt_next   = r_cnt;
        w_stage_next = r_stage;
        case (r_state)
            c_ST_HOLD, c_ST_RELEASE, c_ST_RUN: begin
                if (w_cause_hit) begin
                    w_rst_next   = c_ALL_ON;
                    w_ready_next = 1'b0;
                    w_cause_next = w_cause_code;
                    w_cnt_next   = '0;
                    w_stage_next = c_STAGE_FIRST;
                end else if (r_state == c_ST_HOLD) begin
                    if (w_hold_done) begin
                        w_rst_next   = r_rst << 1;
                        w_ready_next = (NUM_OUTS == 1);
                        w_cnt_next   = '0;
                        w_stage_next = c_STAGE_FIRST;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_ONE;
                    end
                end else if (r_state == c_ST_RELEASE) begin
                    if (w_gap_done) begin
                        w_rst_next   = r_rst << 1;
                        w_ready_next = (r_stage == c_STAGE_LAST);
                        w_cnt_next   = '0;
                        w_stage_next = r_stage + c_STAGE_FIRST;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_ONE;
                    end
                end else begin
                    w_rst_next   = '0;
                    w_ready_next = 1'b1;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_rst_next   = c_ALL_ON;
                w_ready_next = 1'b0;
                w_cnt_next   = '0;
                w_stage_next = c_STAGE_FIRST;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer with a cycle-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int c_N  = 4;
    localparam int c_H  = 32;
    localparam int c_G  = 8;
    localparam int c_DB = 1024;
    localparam logic [c_N-1:0] c_ALL = '1;

    logic           clk        = 1'b0;
    logic           reset      = 1'b1;
    logic           pll_locked = 1'b1;
    logic           btn_n      = 1'b1;
    logic           sw_reset   = 1'b0;
    logic [c_N-1:0] rst_out;
    logic           ready;
    logic [1:0]     cause;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUTS       (c_N),
        .HOLD_CYCLES    (c_H),
        .STAGE_GAP      (c_G),
        .DEBOUNCE_CYCLES(c_DB),
        .CNT_WIDTH      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_locked(pll_locked),
        .btn_n     (btn_n),
        .sw_reset  (sw_reset),
        .rst_out   (rst_out),
        .ready     (ready),
        .cause     (cause)
    );

    // Reference model: phase 0 = just asserted, 1 = waiting for lock/button,
    // 2 = sequencing, with t counting edges since the sequence started.
    logic           m_lock_meta, m_lock_s, m_btn_meta, m_btn_s, m_db;
    int             m_run, m_phase, m_t;
    logic [1:0]     m_cause;
    logic [c_N-1:0] m_rst;
    logic           m_ready;

    function automatic int n_released(input int phase, input int t);
        int n;
        if (phase != 2 || t < c_H) return 0;
        n = 1 + (t - c_H) / c_G;
        return (n > c_N) ? c_N : n;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int         ph, t, run, n;
        logic [1:0] cs;
        logic       db;
        if (reset) begin
            m_lock_meta <= 1'b0;
            m_lock_s    <= 1'b0;
            m_btn_meta  <= 1'b1;
            m_btn_s     <= 1'b1;
            m_db        <= 1'b1;
            m_run       <= 0;
            m_phase     <= 0;
            m_t         <= 0;
            m_cause     <= 2'd0;
            m_rst       <= c_ALL;
            m_ready     <= 1'b0;
        end else begin
            ph = m_phase; t = m_t; cs = m_cause; db = m_db; run = m_run;
            if (ph == 2) begin
                if (!m_lock_s)     begin ph = 0; cs = 2'd1; end
                else if (!m_db)    begin ph = 0; cs = 2'd2; end
                else if (sw_reset) begin ph = 0; cs = 2'd3; end
                else t = t + 1;
            end else if (ph == 1) begin
                if (m_lock_s && m_db) begin ph = 2; t = 0; end
            end else begin
                ph = 1;
            end
            if (m_btn_s != db) begin
                run = run + 1;
                if (run == c_DB) begin db = m_btn_s; run = 0; end
            end else begin
                run = 0;
            end
            n = n_released(ph, t);
            m_phase     <= ph;
            m_t         <= t;
            m_cause     <= cs;
            m_db        <= db;
            m_run       <= run;
            m_lock_s    <= m_lock_meta;
            m_lock_meta <= pll_locked;
            m_btn_s     <= m_btn_meta;
            m_btn_meta  <= btn_n;
            m_rst       <= c_ALL << n;
            m_ready     <= (n == c_N);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rst_out", 32'(rst_out), 32'(m_rst));
            check("model_ready",   32'(ready),   32'(m_ready));
            check("model_cause",   32'(cause),   32'(m_cause));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
    endtask

    initial begin
        // Case 1: power-on sequence, HOLD entered at edge 3 after release.
        step(1);
        chk_en = 1'b1;
        check("por_rst",   32'(rst_out), 32'hF);
        check("por_ready", 32'(ready),   32'h0);
        check("por_cause", 32'(cause),   32'h0);
        do_reset();
        step(34); check("c1_e31_rst", 32'(rst_out), 32'hF);
        step(1);  check("c1_e32_rst", 32'(rst_out), 32'hE);
        step(8);  check("c1_e40_rst", 32'(rst_out), 32'hC);
        step(8);  check("c1_e48_rst", 32'(rst_out), 32'h8);
        step(7);  check("c1_e55_ready", 32'(ready), 32'h0);
        step(1);  check("c1_e56_rst", 32'(rst_out), 32'h0);
                  check("c1_e56_ready", 32'(ready), 32'h1);
                  check("c1_cause", 32'(cause), 32'h0);

        // Case 3: lock loss in RUN; software request while waiting is ignored.
        pll_locked = 1'b0;
        step(2);  check("c3_ready_e2", 32'(ready), 32'h1);
        step(1);  check("c3_rst_e3", 32'(rst_out), 32'hF);
                  check("c3_ready_e3", 32'(ready), 32'h0);
                  check("c3_cause", 32'(cause), 32'h1);
        step(5);
        sw_reset = 1'b1; step(1); sw_reset = 1'b0;
        step(1);  check("c3_sw_ignored", 32'(cause), 32'h1);
        pll_locked = 1'b1;
        step(58); check("c3_relock_ready0", 32'(ready), 32'h0);
        step(1);  check("c3_relock_ready1", 32'(ready), 32'h1);
                  check("c3_cause_held", 32'(cause), 32'h1);

        // Case 4: short press ignored, long press debounced.
        btn_n = 1'b0; step(500); check("c4_short_press", 32'(ready), 32'h1);
        btn_n = 1'b1; step(20);
        btn_n = 1'b0;
        step(1026); check("c4_before_accept", 32'(ready), 32'h1);
        step(1);    check("c4_rst", 32'(rst_out), 32'hF);
                    check("c4_cause", 32'(cause), 32'h2);
        step(73);
        btn_n = 1'b1;
        step(1026); check("c4_still_held", 32'(rst_out), 32'hF);
        step(56);   check("c4_ready0", 32'(ready), 32'h0);
        step(1);    check("c4_ready1", 32'(ready), 32'h1);
                    check("c4_cause_held", 32'(cause), 32'h2);

        // Case 2: lock absent for 100 cycles, software request ignored.
        pll_locked = 1'b0;
        do_reset();
        step(50);
        sw_reset = 1'b1; step(1); sw_reset = 1'b0;
        step(49); check("c2_rst", 32'(rst_out), 32'hF);
                  check("c2_cause", 32'(cause), 32'h0);
        pll_locked = 1'b1;
        step(35); check("c2_e32_rst", 32'(rst_out), 32'hE);
        step(24); check("c2_e56_rst", 32'(rst_out), 32'h0);
                  check("c2_e56_ready", 32'(ready), 32'h1);

        // Case 5: software request while rst_out=1100.
        do_reset();
        step(45); check("c5_pre_rst", 32'(rst_out), 32'hC);
        sw_reset = 1'b1; step(1); sw_reset = 1'b0;
        check("c5_rst", 32'(rst_out), 32'hF);
        check("c5_cause", 32'(cause), 32'h3);

        // Case 6: asynchronous reset mid-RELEASE, between clock edges.
        step(35); check("c6_pre_rst", 32'(rst_out), 32'hE);
        #2 reset = 1'b1;
        #1;
        check("c6_async_rst",   32'(rst_out), 32'hF);
        check("c6_async_ready", 32'(ready),   32'h0);
        check("c6_async_cause", 32'(cause),   32'h0);
        step(1);
        reset = 1'b0;
        step(60); check("c6_run", 32'(ready), 32'h1);
        pll_locked = 1'b0;
        step(2);
        sw_reset = 1'b1; step(1); sw_reset = 1'b0;
        check("c6_prio_cause", 32'(cause), 32'h1);
        check("c6_prio_rst", 32'(rst_out), 32'hF);
        pll_locked = 1'b1;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
